mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 18 +
 rtl/mem_resp_array.sv | 44 ++++
 rtl/mem_responder.sv | 156 +++++++++++++++
 tb/tb_mem_responder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the mem_responder slice: FSM state encodings,
// the default response latency and the latency counter width.
package mem_resp_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2
    } state_e;

    // Default cycles from request acceptance to response.
    localparam int DEFAULT_LATENCY = 2;

    // Latency counter width; covers LATENCY-1 for LATENCY in 1..15.
    localparam int CNT_W = 4;

endpackage : mem_resp_pkg

// File: rtl/mem_resp_array.sv
// Word-addressed storage for mem_responder: synchronous write, asynchronous
// read. With MEM_RESP_BYTE_WRITE_EN defined, writes honour per-byte lane
// enables; otherwise every write updates the full word.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
`ifdef MEM_RESP_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] wbe,
`endif
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Commit a write on the clock edge, either whole word or selected lanes.
    // NOTE: the array has no reset branch on purpose; clearing a RAM would
    // defeat block-RAM inference and contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
`ifdef MEM_RESP_BYTE_WRITE_EN
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wbe[i]) begin
                    mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
`else
            mem_q[waddr] <= wdata;
`endif
        end
    end

    // Combinational read port.
    assign rdata = mem_q[raddr];

endmodule : mem_resp_array

// File: rtl/mem_responder.sv
// Fixed-latency memory responder. Accepts one read or write request in
// IDLE, waits LATENCY cycles, then emits a one-cycle read-valid or
// write-ready pulse. Reads win over a simultaneous write. Requests seen
// while busy are ignored. Optional feature macro: MEM_RESP_BYTE_WRITE_EN
// adds byte_en_in and byte-lane writes.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_en_in,
    input  logic                write_en_in,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   data_in,
`ifdef MEM_RESP_BYTE_WRITE_EN
    input  logic [DATA_W/8-1:0] byte_en_in,
`endif
    output logic [DATA_W-1:0]   data_out,
    output logic                mem_output_valid_out,
    output logic                mem_write_ready_out,
    output logic                busy_out
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
`ifdef MEM_RESP_BYTE_WRITE_EN
    logic [DATA_W/8-1:0] be_q, be_d;
`endif

    logic [DATA_W-1:0] rdata;
    logic              mem_we;

    // Byte-offset bits and bits above the word index do not select storage.
    logic unused_addr;
    assign unused_addr = ^{addr_in[1:0], addr_in[ADDR_W-1:IDX_W+2]};

    // The array is written on the response edge of a write; a reset on that
    // same edge aborts the transaction, so it must also block the commit.
    assign mem_we = (state_q == ST_WRITE_WAIT) && (cnt_q == '0) && !reset;

    mem_resp_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_q),
        .wdata (wdata_q),
`ifdef MEM_RESP_BYTE_WRITE_EN
        .wbe   (be_q),
`endif
        .raddr (idx_q),
        .rdata (rdata)
    );

    // Next-state, counter and response logic for the request FSM.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ready_d    = 1'b0;
`ifdef MEM_RESP_BYTE_WRITE_EN
        be_d       = be_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (read_en_in) begin
                    idx_d   = addr_in[IDX_W+1:2];
                    cnt_d   = CNT_LOAD;
                    state_d = ST_READ_WAIT;
                end else if (write_en_in) begin
                    idx_d   = addr_in[IDX_W+1:2];
                    wdata_d = data_in;
`ifdef MEM_RESP_BYTE_WRITE_EN
                    be_d    = byte_en_in;
`endif
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WRITE_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (cnt_q == '0) begin
                    data_out_d = rdata;
                    valid_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITE_WAIT: begin
                if (cnt_q == '0) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and registered outputs, cleared by synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    // Request datapath latches; only meaningful while a request is in flight.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
`ifdef MEM_RESP_BYTE_WRITE_EN
        be_q    <= be_d;
`endif
    end

    assign data_out             = data_out_q;
    assign mem_output_valid_out = valid_q;
    assign mem_write_ready_out  = ready_q;
    assign busy_out             = (state_q != ST_IDLE);

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder (default parameters,
// LATENCY=2, DEPTH=1024). Byte-lane vectors are included when
// MEM_RESP_BYTE_WRITE_EN is defined.
module tb_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_en_in;
    logic        write_en_in;
    logic [15:0] addr_in;
    logic [31:0] data_in;
    logic [3:0]  byte_en_in;
    logic [31:0] data_out;
    logic        mem_output_valid_out;
    logic        mem_write_ready_out;
    logic        busy_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk                  (clk),
        .reset                (reset),
        .read_en_in           (read_en_in),
        .write_en_in          (write_en_in),
        .addr_in              (addr_in),
        .data_in              (data_in),
`ifdef MEM_RESP_BYTE_WRITE_EN
        .byte_en_in           (byte_en_in),
`endif
        .data_out             (data_out),
        .mem_output_valid_out (mem_output_valid_out),
        .mem_write_ready_out  (mem_write_ready_out),
        .busy_out             (busy_out)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one edge, then check every edge up to the response.
    task automatic do_req(input string tag, input vec_t v);
        bit last;
        read_en_in  = v.rd;
        write_en_in = v.wr;
        addr_in     = v.addr;
        data_in     = v.wdata;
        byte_en_in  = v.be;
        step();
        read_en_in  = 1'b0;
        write_en_in = 1'b0;
        check({tag, " busy after accept"}, 32'(busy_out), 32'd1);
        for (int k = 1; k <= LAT; k++) begin
            step();
            last = (k == LAT);
            check($sformatf("%s valid@%0d", tag, k), 32'(mem_output_valid_out), 32'(last && v.rd));
            check($sformatf("%s ready@%0d", tag, k), 32'(mem_write_ready_out), 32'(last && v.wr && !v.rd));
            check($sformatf("%s busy@%0d", tag, k), 32'(busy_out), 32'(!last));
        end
        if (v.rd) last_rd = v.exp_rd;
        check({tag, " data_out"}, data_out, last_rd);
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [15:0] a, logic [31:0] d,
                                logic [3:0] be, logic [31:0] e);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d; v.be = be; v.exp_rd = e;
        return v;
    endfunction

    initial begin
        vec_t v;

        vecs.push_back(mk(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0));
        vecs.push_back(mk(1, 0, 16'h0010, 32'h0,        4'hF, 32'hDEADBEEF));
        vecs.push_back(mk(0, 1, 16'h0004, 32'h12345678, 4'hF, 32'h0));
        vecs.push_back(mk(1, 1, 16'h0004, 32'hFFFF0000, 4'hF, 32'h12345678));
        vecs.push_back(mk(1, 0, 16'h0004, 32'h0,        4'hF, 32'h12345678));
        vecs.push_back(mk(0, 1, 16'h0008, 32'hA5A5A5A5, 4'hF, 32'h0));
        vecs.push_back(mk(0, 1, 16'h0008 + 16'(4*DEPTH), 32'h5A5A5A5A, 4'hF, 32'h0));
        vecs.push_back(mk(1, 0, 16'h0008, 32'h0,        4'hF, 32'h5A5A5A5A));
        vecs.push_back(mk(1, 0, 16'h000B, 32'h0,        4'hF, 32'h5A5A5A5A));
        vecs.push_back(mk(0, 1, 16'h0FFC, 32'hCAFEF00D, 4'hF, 32'h0));
        vecs.push_back(mk(1, 0, 16'hFFFC, 32'h0,        4'hF, 32'hCAFEF00D));
`ifdef MEM_RESP_BYTE_WRITE_EN
        vecs.push_back(mk(0, 1, 16'h0020, 32'h11223344, 4'hF,    32'h0));
        vecs.push_back(mk(0, 1, 16'h0020, 32'hAABBCCDD, 4'b0101, 32'h0));
        vecs.push_back(mk(1, 0, 16'h0020, 32'h0,        4'hF,    32'h11BB33DD));
`endif

        // Reset, then five idle cycles with all outputs low.
        reset = 1'b1; read_en_in = 1'b0; write_en_in = 1'b0;
        addr_in = '0; data_in = '0; byte_en_in = 4'hF;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("idle%0d data_out", i), data_out, 32'h0);
            check($sformatf("idle%0d valid", i), 32'(mem_output_valid_out), 32'd0);
            check($sformatf("idle%0d ready", i), 32'(mem_write_ready_out), 32'd0);
            check($sformatf("idle%0d busy", i), 32'(busy_out), 32'd0);
        end

        // Directed vector table.
        foreach (vecs[i]) do_req($sformatf("vec%0d", i), vecs[i]);

        // Reset one cycle after write acceptance aborts the write.
        read_en_in = 1'b0; write_en_in = 1'b1;
        addr_in = 16'h0010; data_in = 32'h0BADF00D; byte_en_in = 4'hF;
        step();
        write_en_in = 1'b0;
        check("abort busy after accept", 32'(busy_out), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy after reset", 32'(busy_out), 32'd0);
        check("abort ready after reset", 32'(mem_write_ready_out), 32'd0);
        check("abort data_out cleared", data_out, 32'h0);
        last_rd = 32'h0;
        step();
        check("abort no late ready", 32'(mem_write_ready_out), 32'd0);
        do_req("abort readback", mk(1, 0, 16'h0010, 32'h0, 4'hF, 32'hDEADBEEF));

        // Requests held through busy are ignored; next accept at N+LAT+1.
        read_en_in = 1'b1; addr_in = 16'h0010;
        step();                                  // edge N
        addr_in = 16'h0008; write_en_in = 1'b1; data_in = 32'h77777777;
        step();                                  // edge N+1
        check("hold valid N+1", 32'(mem_output_valid_out), 32'd0);
        check("hold ready N+1", 32'(mem_write_ready_out), 32'd0);
        step();                                  // edge N+2
        check("hold valid N+2", 32'(mem_output_valid_out), 32'd1);
        check("hold data N+2", data_out, 32'hDEADBEEF);
        check("hold busy N+2", 32'(busy_out), 32'd0);
        step();                                  // edge N+3: second read accepted
        check("hold valid N+3", 32'(mem_output_valid_out), 32'd0);
        check("hold busy N+3", 32'(busy_out), 32'd1);
        read_en_in = 1'b0; write_en_in = 1'b0;
        step();                                  // edge N+4
        check("hold valid N+4", 32'(mem_output_valid_out), 32'd0);
        step();                                  // edge N+5
        check("hold valid N+5", 32'(mem_output_valid_out), 32'd1);
        check("hold data N+5", data_out, 32'h5A5A5A5A);
        check("hold ready N+5", 32'(mem_write_ready_out), 32'd0);
        last_rd = 32'h5A5A5A5A;
        step();
        check("hold data kept", data_out, last_rd);

        v = mk(1, 0, 16'h0008, 32'h0, 4'hF, 32'h5A5A5A5A);
        do_req("no stray write", v);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mem_responder
